// File: rtl/gate_chk_pkg.sv
`default_nettype none
//==============================================================================
// Module      : gate_chk_pkg
// Description : Shared types and truth-table constants for the 2-input gate
//               checker (FSM state encoding, vector type, common gate tables).
//               Truth-table bit index is the vector {in_1,in_2}.
// Revision    : 1.0 - initial release
//==============================================================================
package gate_chk_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        SAMPLE = 3'd3,
        DONE   = 3'd4
    } state_t;

    typedef logic [1:0] vec_t;

    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_XOR  = 4'b0110;
    localparam logic [3:0] TT_NAND = 4'b0111;

    // Expected gate output for one input vector.
    function automatic logic tt_bit(input logic [3:0] tt, input vec_t v);
        return tt[v];
    endfunction

endpackage
`default_nettype wire

// File: rtl/gate_chk_settle_timer.sv
`default_nettype none
//==============================================================================
// Module      : gate_chk_settle_timer
// Description : Loadable down-counter that times how long a stimulus vector is
//               held before its response is sampled.
// Ports       : clk, rst      - clock, synchronous active-high reset
//               load, value   - load the counter with value (priority over dec)
//               dec           - decrement by one, stops at zero
//               expired       - counter is zero
// Revision    : 1.0 - initial release
//==============================================================================
module gate_chk_settle_timer
    import gate_chk_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             dec,
    input  logic [WIDTH-1:0] value,
    output logic             expired
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= value;
        end else if (dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/gate_truth_checker.sv
`default_nettype none
//==============================================================================
// Module      : gate_truth_checker
// Description : Synthesizable stimulus/response checker for a 2-input gate.
//               Sweeps vectors 00,01,10,11 (REPEAT times), holds each for
//               SETTLE_CYCLES+1 clocks, compares the sampled gate output with
//               TRUTH and reports pass, error count and first failing vector.
// Ports       : clk, reset (sync, active-high), start (accepted in IDLE only)
//               dut_in_1/dut_in_2 -> gate inputs, dut_out <- gate output
//               busy, done (1-cycle pulse), pass, err_count, first_fail_vec
//               observed_table (only with GATE_CHK_CAPTURE_EN)
// Config      : GATE_CHK_CAPTURE_EN - adds observed_table[3:0], the gate
//               output captured per vector during the last sweep.
// Revision    : 1.0 - initial release
//==============================================================================
module gate_truth_checker
    import gate_chk_pkg::*;
#(
    parameter logic [3:0] TRUTH         = TT_AND,
    parameter int         SETTLE_CYCLES = 1,
    parameter int         REPEAT        = 1,
    localparam int        c_ERR_W       = $clog2(4*REPEAT+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               dut_in_1,
    output logic               dut_in_2,
    input  logic               dut_out,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [c_ERR_W-1:0] err_count,
    output logic [1:0]         first_fail_vec
`ifdef GATE_CHK_CAPTURE_EN
    ,
    output logic [3:0]         observed_table
`endif
);

    localparam int                 c_SW_W       = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [c_SW_W-1:0]  c_LAST_SWEEP = c_SW_W'(REPEAT-1);
    localparam int                 c_TMR_W      = $clog2(SETTLE_CYCLES+1);
    localparam logic [c_TMR_W-1:0] c_TMR_LOAD   = c_TMR_W'(SETTLE_CYCLES-1);
    localparam logic [c_ERR_W-1:0] c_ERR_MAX    = '1;

    state_t              r_state;
    state_t              w_state_next;
    vec_t                r_idx;
    logic [c_SW_W-1:0]   r_sweep;
    vec_t                r_dut_in;
    logic [c_ERR_W-1:0]  r_err;
    logic                r_pass;
    vec_t                r_ffv;
    logic                w_tmr_expired;
    logic                w_mismatch;
    logic                w_last;

    gate_chk_settle_timer #(
        .WIDTH (c_TMR_W)
    ) u_timer (
        .clk     (clk),
        .rst     (reset),
        .load    (r_state == DRIVE),
        .dec     (r_state == SETTLE),
        .value   (c_TMR_LOAD),
        .expired (w_tmr_expired)
    );

    assign w_mismatch = (dut_out != tt_bit(TRUTH, r_idx));
    assign w_last     = (r_idx == 2'd3) && (r_sweep == c_LAST_SWEEP);

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start) w_state_next = DRIVE;
            DRIVE:   w_state_next = SETTLE;
            SETTLE:  if (w_tmr_expired) w_state_next = SAMPLE;
            SAMPLE:  w_state_next = w_last ? DONE : DRIVE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Vector/sweep counters, stimulus register and result registers
    always_ff @(posedge clk) begin
        if (reset) begin
            r_idx    <= '0;
            r_sweep  <= '0;
            r_dut_in <= '0;
            r_err    <= '0;
            r_pass   <= 1'b0;
            r_ffv    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idx   <= '0;
                        r_sweep <= '0;
                        r_err   <= '0;
                        r_pass  <= 1'b0;
                        r_ffv   <= '0;
                    end
                end
                DRIVE: begin
                    // The only point where the gate inputs move, so the
                    // vector is stable through SETTLE and SAMPLE.
                    r_dut_in <= r_idx;
                end
                SAMPLE: begin
                    if (w_mismatch) begin
                        if (r_err != c_ERR_MAX) begin
                            r_err <= r_err + c_ERR_W'(1);
                        end
                        // The counter saturates and never wraps, so zero
                        // reliably marks "no mismatch seen yet".
                        if (r_err == '0) begin
                            r_ffv <= r_idx;
                        end
                    end
                    if (w_last) begin
                        r_pass  <= (r_err == '0) && !w_mismatch;
                        r_idx   <= '0;
                        r_sweep <= '0;
                    end else begin
                        r_idx <= r_idx + 2'd1;
                        if (r_idx == 2'd3) begin
                            r_sweep <= r_sweep + c_SW_W'(1);
                        end
                    end
                end
                DONE: begin
                    r_dut_in <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef GATE_CHK_CAPTURE_EN
    logic [3:0] r_obs;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_obs <= '0;
        end else if ((r_state == IDLE) && start) begin
            r_obs <= '0;
        end else if (r_state == SAMPLE) begin
            // Later sweeps overwrite earlier ones.
            r_obs[r_idx] <= dut_out;
        end
    end

    assign observed_table = r_obs;
`endif

    assign dut_in_1       = r_dut_in[1];
    assign dut_in_2       = r_dut_in[0];
    assign busy           = (r_state == DRIVE) || (r_state == SETTLE) || (r_state == SAMPLE);
    assign done           = (r_state == DONE);
    assign pass           = r_pass;
    assign err_count      = r_err;
    assign first_fail_vec = r_ffv;

endmodule
`default_nettype wire

// File: tb/tb_gate_truth_checker.sv
`default_nettype none
//==============================================================================
// Module      : tb_gate_truth_checker
// Description : Self-checking bench for gate_truth_checker. Instance A checks
//               a selectable gate against TT_AND (defaults); instance B checks
//               an XOR gate with REPEAT=2, SETTLE_CYCLES=3. Expected results
//               are queued at start and compared when done pulses.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_gate_truth_checker;
    import gate_chk_pkg::*;

    localparam int c_EW_A = $clog2(5);
    localparam int c_EW_B = $clog2(9);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, start_b;
    logic a_in1, a_in2, a_out, busy_a, done_a, pass_a;
    logic b_in1, b_in2, b_out, busy_b, done_b, pass_b;
    logic [c_EW_A-1:0] err_a;
    logic [c_EW_B-1:0] err_b;
    logic [1:0] ffv_a, ffv_b;
`ifdef GATE_CHK_CAPTURE_EN
    logic [3:0] obs_a, obs_b;
`endif
    int gate_sel;

    // Gate under test for instance A: 0=AND, 1=stuck-at-0, other=NAND
    always_comb begin
        a_out = 1'b0;
        case (gate_sel)
            0:       a_out = a_in1 & a_in2;
            1:       a_out = 1'b0;
            default: a_out = ~(a_in1 & a_in2);
        endcase
    end
    assign b_out = b_in1 ^ b_in2;

    gate_truth_checker #(.TRUTH(TT_AND), .SETTLE_CYCLES(1), .REPEAT(1)) u_dut_a (
`ifdef GATE_CHK_CAPTURE_EN
        .observed_table (obs_a),
`endif
        .clk            (clk),
        .reset          (reset),
        .start          (start_a),
        .dut_in_1       (a_in1),
        .dut_in_2       (a_in2),
        .dut_out        (a_out),
        .busy           (busy_a),
        .done           (done_a),
        .pass           (pass_a),
        .err_count      (err_a),
        .first_fail_vec (ffv_a)
    );

    gate_truth_checker #(.TRUTH(TT_XOR), .SETTLE_CYCLES(3), .REPEAT(2)) u_dut_b (
`ifdef GATE_CHK_CAPTURE_EN
        .observed_table (obs_b),
`endif
        .clk            (clk),
        .reset          (reset),
        .start          (start_b),
        .dut_in_1       (b_in1),
        .dut_in_2       (b_in2),
        .dut_out        (b_out),
        .busy           (busy_b),
        .done           (done_b),
        .pass           (pass_b),
        .err_count      (err_b),
        .first_fail_vec (ffv_b)
    );

    typedef struct {
        int err;
        int ffv;
        int pass;
        int lat;
        int obs;
        int seq;
        int nseq;
        int acc;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Stimulus log: distinct consecutive gate-input vectors seen while busy
    int seq_a = 0, nseq_a = 0, last_a = 0;
    int seq_b = 0, nseq_b = 0, last_b = 0;

    // Monitor A
    always @(negedge clk) begin
        if (reset) begin
            seq_a = 0; nseq_a = 0;
        end else begin
            if (busy_a && (nseq_a == 0 || int'({a_in1, a_in2}) != last_a)) begin
                last_a = int'({a_in1, a_in2});
                seq_a  = seq_a * 4 + last_a;
                nseq_a++;
            end
            if (done_a) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_done", 1, 0);
                end else begin
                    e_a = q_a.pop_front();
                    chk("a_err_count", int'(err_a), e_a.err);
                    chk("a_first_fail_vec", int'(ffv_a), e_a.ffv);
                    chk("a_pass", int'(pass_a), e_a.pass);
                    chk("a_latency", cyc - e_a.acc, e_a.lat);
                    chk("a_busy_at_done", int'(busy_a), 0);
                    chk("a_stim_sequence", seq_a, e_a.seq);
                    chk("a_stim_count", nseq_a, e_a.nseq);
`ifdef GATE_CHK_CAPTURE_EN
                    chk("a_observed_table", int'(obs_a), e_a.obs);
`endif
                end
                seq_a = 0; nseq_a = 0;
            end
        end
    end

    // Monitor B
    always @(negedge clk) begin
        if (reset) begin
            seq_b = 0; nseq_b = 0;
        end else begin
            if (busy_b && (nseq_b == 0 || int'({b_in1, b_in2}) != last_b)) begin
                last_b = int'({b_in1, b_in2});
                seq_b  = seq_b * 4 + last_b;
                nseq_b++;
            end
            if (done_b) begin
                if (q_b.size() == 0) begin
                    chk("b_unexpected_done", 1, 0);
                end else begin
                    e_b = q_b.pop_front();
                    chk("b_err_count", int'(err_b), e_b.err);
                    chk("b_first_fail_vec", int'(ffv_b), e_b.ffv);
                    chk("b_pass", int'(pass_b), e_b.pass);
                    chk("b_latency", cyc - e_b.acc, e_b.lat);
                    chk("b_busy_at_done", int'(busy_b), 0);
                    chk("b_stim_sequence", seq_b, e_b.seq);
                    chk("b_stim_count", nseq_b, e_b.nseq);
`ifdef GATE_CHK_CAPTURE_EN
                    chk("b_observed_table", int'(obs_b), e_b.obs);
`endif
                end
                seq_b = 0; nseq_b = 0;
            end
        end
    end

    // Start a run on A and queue its expected result (SETTLE=1, REPEAT=1).
    task automatic launch_a(input int err, input int ffv, input int pass, input int obs);
        exp_t e;
        @(negedge clk);
        start_a = 1'b1;
        e.err = err; e.ffv = ffv; e.pass = pass; e.lat = 12; e.obs = obs;
        e.seq = 27; e.nseq = 4; e.acc = cyc + 1;
        q_a.push_back(e);
        @(negedge clk);
        start_a = 1'b0;
        chk("a_busy_after_start", int'(busy_a), 1);
    endtask

    task automatic wait_a_done(input string name);
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (done_a) return;
        end
        chk(name, 0, 1);
    endtask

    task automatic wait_b_done(input string name);
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (done_b) return;
        end
        chk(name, 0, 1);
    endtask

    initial begin
        exp_t eb;
        reset    = 1'b1;
        start_a  = 1'b0;
        start_b  = 1'b0;
        gate_sel = 0;
        repeat (3) @(negedge clk);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_pass", int'(pass_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_ffv", int'(ffv_a), 0);
        chk("rst_dut_in", int'({a_in1, a_in2}), 0);
        chk("rst_b_busy", int'(busy_b), 0);
        reset = 1'b0;

        // AND gate, matching table
        gate_sel = 0;
        launch_a(0, 0, 1, 8);
        wait_a_done("t1_done_timeout");
        // start during the DONE cycle must be ignored
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        chk("a_start_in_done_ignored", int'(busy_a), 0);
        repeat (3) @(negedge clk);
        chk("a_pass_holds", int'(pass_a), 1);
        chk("a_idle_dut_in", int'({a_in1, a_in2}), 0);

        // Stuck-at-0: only vector 11 mismatches
        gate_sel = 1;
        launch_a(1, 3, 0, 0);
        wait_a_done("t2_done_timeout");

        // NAND against AND table: every vector mismatches
        gate_sel = 2;
        launch_a(4, 0, 0, 7);
        wait_a_done("t3_done_timeout");

        // XOR, two sweeps, SETTLE_CYCLES=3: 4*2*5 = 40 cycles
        @(negedge clk);
        start_b = 1'b1;
        eb.err = 0; eb.ffv = 0; eb.pass = 1; eb.lat = 40; eb.obs = 6;
        eb.seq = 16'h1B1B; eb.nseq = 8; eb.acc = cyc + 1;
        q_b.push_back(eb);
        @(negedge clk);
        start_b = 1'b0;
        chk("b_busy_after_start", int'(busy_b), 1);
        wait_b_done("t4_done_timeout");

        // start re-pulsed at cycle 5 of a run: no effect on result or timing
        gate_sel = 0;
        launch_a(0, 0, 1, 8);
        repeat (4) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        wait_a_done("t5_done_timeout");

        // Reset in SETTLE of vector 10 after two NAND mismatches
        gate_sel = 2;
        repeat (2) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        repeat (7) @(negedge clk);
        chk("a_err_before_abort", int'(err_a), 2);
        chk("a_busy_before_abort", int'(busy_a), 1);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_err", int'(err_a), 0);
        chk("abort_pass", int'(pass_a), 0);
        chk("abort_dut_in", int'({a_in1, a_in2}), 0);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_stays_idle", int'(busy_a), 0);

        // Clean run after the abort
        gate_sel = 0;
        launch_a(0, 0, 1, 8);
        wait_a_done("t6_done_timeout");

        repeat (3) @(negedge clk);
        chk("a_queue_drained", q_a.size(), 0);
        chk("b_queue_drained", q_b.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
